switch_conditioner: RTL
=======================

# switch_conditioner

Input-conditioning stage between the raw board switches and the `picomips` core. It synchronises the nine user switches (eight data bits plus the handshake bit) into the `Clock` domain and debounces them. It presents the core with a clean, glitch-free handshake level, a one-cycle rising-edge pulse, and a data byte that stays frozen while the handshake is asserted. The core's `SW[7:0]` and `SW[8]` inputs are driven from this block's outputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before any output changes. Legal range is 2..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width. Derived only; never overridden.

Ports:
- `Clock` in, 1: single system clock, rising-edge.
- `nReset` in, 1: asynchronous, active-low reset.
- `SWRaw` in, 9: raw switch pins, asynchronous to `Clock`. `[7:0]` is data; `[8]` is the handshake.
- `SWData` out, 8: debounced, frozen data byte for the core's `SW[7:0]`.
- `Handshake` out, 1: debounced handshake level for the core's `SW[8]`.
- `HandshakeEdge` out, 1: one-cycle pulse in the cycle `Handshake` first reads 1.
- `Pending` out, 1: high while the captured candidate data differs from `SWData`.

## Operation
- **Reset (async, `nReset`=0):**
  - Clears both synchroniser stages, the candidate register `Cand`, both counters and all outputs.
  - Reset values: `SWData`=0, `Handshake`=0, `HandshakeEdge`=0, `Pending`=0.
  - The reset takes effect immediately, including mid-debounce. Partial counts are discarded.
- **Synchroniser:**
  - Two flops on all nine bits: `sync1`, then `sync2`.
  - Only `sync2` is used downstream.
- **Handshake FSM, states `LOW`, `HIGH`, with counter `HCnt`:**
  - A mismatch means `sync2[8]` differs from the current level.
  - On each edge with a mismatch:
    - If `HCnt`==`DEBOUNCE_CYCLES`-1: toggle the state and clear `HCnt`.
    - Otherwise increment `HCnt`.
  - Any edge without a mismatch clears `HCnt`, so a glitch restarts the count.
  - `Handshake` is 1 in `HIGH`.
  - `HandshakeEdge` is registered and is 1 only for the first cycle after a `LOW` to `HIGH` transition. Falling transitions produce no pulse.
- **Data path, with `Cand[7:0]` and counter `DCnt`:**
  - If `sync2[7:0]` differs from `Cand`: load `Cand` and clear `DCnt`.
  - Else, if `Cand` differs from `SWData`:
    - If `DCnt`==`DEBOUNCE_CYCLES`-1, `Handshake`=0, and the handshake FSM is not toggling to `HIGH` on this edge: load `SWData` with `Cand` and clear `DCnt`.
    - Otherwise increment `DCnt`, saturating at `DEBOUNCE_CYCLES`-1.
  - Else hold `DCnt` at 0.
  - `Pending` = (`Cand` differs from `SWData`), combinational from registers.
- **Freeze:** `SWData` never changes while `Handshake`=1. A saturated `DCnt` commits on the first edge at which `Handshake` is 0.
- **Arithmetic:**
  - Counters are unsigned, `CNT_W` bits wide.
  - Counters never wrap; saturation is mandatory.
  - No signed interpretation is applied here. The core treats the byte as signed.

## Timing
Let N=`DEBOUNCE_CYCLES`. "Edge k" means the k-th rising edge after the raw change, with the raw input stable from before edge 0.
- `sync2` reflects the raw change after edge 1.
- `Handshake` changes after edge N+1. `HandshakeEdge` is high during the cycle following edge N+1, for exactly one cycle.
- `SWData` updates after edge N+2, provided `Handshake` is 0.
- `Pending` rises after edge 2 and falls after edge N+2.
- Minimum qualifying pulse on `SWRaw[8]`: N+0 stable samples at `sync2`. Any shorter pulse produces no output change.
- Data and handshake changing on the same edge: the handshake rises after edge N+1. The data update at edge N+2 is blocked, so the core sees the old data until the handshake falls.
- Handshake release: falling at edge M, followed by a pending data update, gives `SWData` updating after edge M+1.

## Test plan
Bench uses N=4.
- **Reset:** hold `nReset`=0 with `SWRaw`=9'h1FF, then release → all outputs 0 immediately. `Handshake` rises after edge 5 and `HandshakeEdge` pulses once. `SWData` stays 0 (frozen) until `SWRaw[8]` drops.
- **Data debounce:** `SWRaw`=9'h05A, stable → `Pending`=1 after edge 2, `SWData`=8'h5A after edge 6, `Handshake`=0 throughout.
- **Glitch rejection:** toggle `SWRaw[8]` high for 3 cycles, then low → `Handshake` and `HandshakeEdge` never assert; `HCnt` returns to 0.
- **Freeze:** set data 8'h10 and settle, raise the handshake and settle, then change data to 8'hF0 → `SWData` holds 8'h10 while `Handshake`=1. Drop the handshake; once `Handshake`=0, `SWData` becomes 8'hF0 one edge later.
- **Simultaneous change:** from idle, set `SWRaw`=9'h1AA on one edge → `Handshake`=1 after edge 5 and `SWData` stays 0. Drop `SWRaw[8]` → `SWData`=8'hAA one edge after `Handshake` falls.
- **Reset mid-count:** assert `nReset`=0 at edge 3 of a handshake debounce → outputs stay 0. After release, the full 2+N latency restarts.

Source files
------------

// File: rtl/switch_conditioner.sv
// Switch input conditioner: synchronises the nine raw switches, debounces the
// handshake level, and presents a data byte that is frozen while the handshake is high.
module switch_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [8:0] SWRaw,
    output logic [7:0] SWData,
    output logic       Handshake,
    output logic       HandshakeEdge,
    output logic       Pending
);

    localparam logic [0:0] StLow  = 1'b0;
    localparam logic [0:0] StHigh = 1'b1;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [8:0]       sync1_q, sync2_q;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             hs_edge_q, hs_rise;
    logic [7:0]       cand_q, cand_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             hs_mismatch;

    // Two-flop synchroniser on all nine switch bits.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SWRaw;
            sync2_q <= sync1_q;
        end
    end

    assign hs_mismatch = sync2_q[8] != (state_q == StHigh);

    // Handshake debounce: N consecutive mismatching samples toggle the level; any match restarts.
    always_comb begin
        state_d = state_q;
        hcnt_d  = '0;
        hs_rise = 1'b0;
        if (hs_mismatch) begin
            if (hcnt_q == CntMax) begin
                state_d = (state_q == StHigh) ? StLow : StHigh;
                hs_rise = (state_q == StLow);
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Data candidate tracking and commit; commits are blocked while the handshake is (or is
    // about to become) high, so the core never sees data move under an asserted handshake.
    always_comb begin
        cand_d = cand_q;
        data_d = data_q;
        dcnt_d = dcnt_q;
        if (sync2_q[7:0] != cand_q) begin
            cand_d = sync2_q[7:0];
            dcnt_d = '0;
        end else if (cand_q != data_q) begin
            if (dcnt_q == CntMax && state_q == StLow && !hs_rise) begin
                data_d = cand_q;
                dcnt_d = '0;
            end else if (dcnt_q != CntMax) begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end else begin
            dcnt_d = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= StLow;
            hcnt_q    <= '0;
            hs_edge_q <= 1'b0;
            cand_q    <= '0;
            data_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            hs_edge_q <= hs_rise;
            cand_q    <= cand_d;
            data_q    <= data_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign SWData        = data_q;
    assign Handshake     = (state_q == StHigh);
    assign HandshakeEdge = hs_edge_q;
    assign Pending       = (cand_q != data_q);

endmodule
